// File: rtl/rf_pkg.sv
// Shared types and default widths for the register-file arbiter.
package rf_pkg;

    localparam int unsigned REG_SIZE   = 32;
    localparam int unsigned INDEX_SIZE = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [INDEX_SIZE-1:0] addr_s;
        logic [INDEX_SIZE-1:0] addr_t;
        logic                  we;
        logic [INDEX_SIZE-1:0] waddr;
        logic [REG_SIZE-1:0]   wdata;
    } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a last-grant register; last_grant is the index of the most recent winner.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

    // Reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (update && (req != 2'b00)) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/rf_arbiter.sv
// Two-requester front end for a handshaked register file (IDLE/ISSUE/WAIT/RESP).
// Optional WAIT timeout with err reporting is enabled by defining RF_ARB_TIMEOUT_EN.
module rf_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned REG_SIZE       = rf_pkg::REG_SIZE,
    parameter int unsigned INDEX_SIZE     = rf_pkg::INDEX_SIZE
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [INDEX_SIZE-1:0] addr_s0,
    input  logic [INDEX_SIZE-1:0] addr_s1,
    input  logic [INDEX_SIZE-1:0] addr_t0,
    input  logic [INDEX_SIZE-1:0] addr_t1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [INDEX_SIZE-1:0] waddr0,
    input  logic [INDEX_SIZE-1:0] waddr1,
    input  logic [REG_SIZE-1:0]   wdata0,
    input  logic [REG_SIZE-1:0]   wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [REG_SIZE-1:0]   rd_a,
    output logic [REG_SIZE-1:0]   rd_b,
    output logic                  err,
    output logic                  rf_start,
    output logic                  rf_read_enabled,
    output logic                  rf_write_enabled,
    output logic [INDEX_SIZE-1:0] rf_read_addr_s,
    output logic [INDEX_SIZE-1:0] rf_read_addr_t,
    output logic [INDEX_SIZE-1:0] rf_write_addr,
    output logic [REG_SIZE-1:0]   rf_write_data,
    input  logic                  rf_finish,
    input  logic [REG_SIZE-1:0]   rf_outA,
    input  logic [REG_SIZE-1:0]   rf_outB
);

    state_t     state, next_state;
    cmd_t       cmd;
    logic [1:0] gnt;
    logic       last_grant;
    logic       issue_go;
    logic       finish_go;
    logic       timeout_go;
    logic       active;

    assign issue_go  = (state == IDLE) && (req0 || req1);
    assign finish_go = (state == WAIT) && rf_finish;

    // last_grant doubles as the owner of the in-flight transaction.
    rr_arb2 u_arb (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        ({req1, req0}),
        .update     (issue_go),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

`ifdef RF_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    // Finish wins over a timeout landing in the same cycle.
    assign timeout_go = (state == WAIT) && !rf_finish
                        && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == WAIT) begin
                timed_out <= timeout_go;
            end
        end
    end

    assign err = (state == RESP) && timed_out;
`else
    assign timeout_go = 1'b0;
    assign err        = 1'b0;
`endif

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (req0 || req1) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (finish_go || timeout_go) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        active           = (state == ISSUE) || (state == WAIT);
        rf_start         = (state == ISSUE);
        rf_read_enabled  = active;
        rf_write_enabled = active && cmd.we;
        rf_read_addr_s   = active ? cmd.addr_s : '0;
        rf_read_addr_t   = active ? cmd.addr_t : '0;
        rf_write_addr    = active ? cmd.waddr  : '0;
        rf_write_data    = active ? cmd.wdata  : '0;
        ack0             = (state == RESP) && !last_grant;
        ack1             = (state == RESP) && last_grant;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cmd   <= '0;
            rd_a  <= '0;
            rd_b  <= '0;
        end else begin
            state <= next_state;
            if (issue_go) begin
                if (gnt == 2'b10) begin
                    cmd <= '{addr_s: addr_s1, addr_t: addr_t1, we: we1, waddr: waddr1, wdata: wdata1};
                end else begin
                    cmd <= '{addr_s: addr_s0, addr_t: addr_t0, we: we0, waddr: waddr0, wdata: wdata0};
                end
            end
            if (finish_go) begin
                rd_a <= rf_outA;
                rd_b <= rf_outB;
            end else if (timeout_go) begin
                rd_a <= '0;
                rd_b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rf_arbiter.sv
// Directed bench for rf_arbiter with a small behavioural register file on the rf_* side.
module tb_rf_arbiter;

    localparam int unsigned RS = 32;
    localparam int unsigned IS = 5;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req0, req1;
    logic [IS-1:0] addr_s0, addr_s1, addr_t0, addr_t1;
    logic          we0, we1;
    logic [IS-1:0] waddr0, waddr1;
    logic [RS-1:0] wdata0, wdata1;
    logic          ack0, ack1, err;
    logic [RS-1:0] rd_a, rd_b;
    logic          rf_start, rf_read_enabled, rf_write_enabled;
    logic [IS-1:0] rf_read_addr_s, rf_read_addr_t, rf_write_addr;
    logic [RS-1:0] rf_write_data;
    logic          rf_finish;
    logic [RS-1:0] rf_outA, rf_outB;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [RS-1:0] regs [32];
    int unsigned   fin_delay = 0;
    bit            fin_hold  = 1'b0;
    int unsigned   wcnt      = 0;

    always #5 clock = ~clock;

    rf_arbiter #(.TIMEOUT_CYCLES(16), .REG_SIZE(RS), .INDEX_SIZE(IS)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req0             (req0),
        .req1             (req1),
        .addr_s0          (addr_s0),
        .addr_s1          (addr_s1),
        .addr_t0          (addr_t0),
        .addr_t1          (addr_t1),
        .we0              (we0),
        .we1              (we1),
        .waddr0           (waddr0),
        .waddr1           (waddr1),
        .wdata0           (wdata0),
        .wdata1           (wdata1),
        .ack0             (ack0),
        .ack1             (ack1),
        .rd_a             (rd_a),
        .rd_b             (rd_b),
        .err              (err),
        .rf_start         (rf_start),
        .rf_read_enabled  (rf_read_enabled),
        .rf_write_enabled (rf_write_enabled),
        .rf_read_addr_s   (rf_read_addr_s),
        .rf_read_addr_t   (rf_read_addr_t),
        .rf_write_addr    (rf_write_addr),
        .rf_write_data    (rf_write_data),
        .rf_finish        (rf_finish),
        .rf_outA          (rf_outA),
        .rf_outB          (rf_outB)
    );

    // Register file: finish after fin_delay WAIT cycles, write on finish.
    assign rf_finish = rf_read_enabled && !rf_start && !fin_hold && (wcnt == fin_delay);
    assign rf_outA   = regs[rf_read_addr_s];
    assign rf_outB   = regs[rf_read_addr_t];

    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            regs[3] <= 32'h11;
            regs[4] <= 32'h22;
        end else if (rf_finish && rf_write_enabled) begin
            regs[rf_write_addr] <= rf_write_data;
        end
        if (rf_start) wcnt <= 0;
        else if (rf_read_enabled) wcnt <= wcnt + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n_ack, starts, dbl, both, acks, early;
        int          ord [4];
        bit          prev, stable;

        reset_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr_s0 = '0; addr_s1 = '0; addr_t0 = '0; addr_t1 = '0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) tick();

        check_vec("rst_ack0", ack0, 0);
        check_vec("rst_ack1", ack1, 0);
        check_vec("rst_err", err, 0);
        check_vec("rst_start", rf_start, 0);
        check_vec("rst_rden", rf_read_enabled, 0);
        check_vec("rst_wren", rf_write_enabled, 0);
        check_vec("rst_raddr_s", rf_read_addr_s, 0);
        check_vec("rst_wdata", rf_write_data, 0);
        check_vec("rst_rd_a", rd_a, 0);
        check_vec("rst_rd_b", rd_b, 0);

        // Single read, minimum latency
        reset_n = 1'b1;
        req0 = 1; addr_s0 = 3; addr_t0 = 4;
        tick();
        check_vec("rd_start", rf_start, 1);
        check_vec("rd_addr_s", rf_read_addr_s, 3);
        check_vec("rd_addr_t", rf_read_addr_t, 4);
        check_vec("rd_wren", rf_write_enabled, 0);
        check_vec("rd_ack0_issue", ack0, 0);
        tick();
        check_vec("rd_wait_rden", rf_read_enabled, 1);
        check_vec("rd_wait_start", rf_start, 0);
        check_vec("rd_ack0_wait", ack0, 0);
        tick();
        check_vec("rd_ack0", ack0, 1);
        check_vec("rd_ack1", ack1, 0);
        check_vec("rd_a", rd_a, 32'h11);
        check_vec("rd_b", rd_b, 32'h22);
        check_vec("rd_err", err, 0);
        check_vec("rd_resp_rden", rf_read_enabled, 0);
        req0 = 0;
        tick();
        check_vec("rd_ack0_once", ack0, 0);
        check_vec("rd_a_hold", rd_a, 32'h11);

        // Write then read
        req1 = 1; we1 = 1; waddr1 = 5; wdata1 = 32'hDEADBEEF; addr_s1 = 1; addr_t1 = 2;
        tick();
        check_vec("wr_wren", rf_write_enabled, 1);
        check_vec("wr_waddr", rf_write_addr, 5);
        check_vec("wr_wdata", rf_write_data, 32'hDEADBEEF);
        tick(); tick();
        check_vec("wr_ack1", ack1, 1);
        check_vec("wr_ack0", ack0, 0);
        req1 = 0; we1 = 0;
        tick();
        req0 = 1; addr_s0 = 5; addr_t0 = 3;
        tick(); tick(); tick();
        check_vec("wrrd_ack0", ack0, 1);
        check_vec("wrrd_rd_a", rd_a, 32'hDEADBEEF);
        check_vec("wrrd_rd_b", rd_b, 32'h11);
        req0 = 0;
        tick();

        // Write to index 0 forwarded; req dropped after grant still acked
        req0 = 1; we0 = 1; waddr0 = 0; wdata0 = 32'h12345678;
        tick();
        check_vec("w0_waddr", rf_write_addr, 0);
        check_vec("w0_wdata", rf_write_data, 32'h12345678);
        check_vec("w0_wren", rf_write_enabled, 1);
        req0 = 0;
        tick(); tick();
        check_vec("drop_ack0", ack0, 1);
        we0 = 0;
        tick();

        // Slow finish: 7 extra WAIT cycles
        fin_delay = 7;
        req0 = 1; addr_s0 = 4; addr_t0 = 3;
        tick();
        stable = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rf_read_addr_s !== 4 || rf_read_addr_t !== 3 || rf_read_enabled !== 1 ||
                rf_start !== 0 || ack0 !== 0)
                stable = 0;
        end
        check_vec("slow_stable", stable, 1);
        tick();
        check_vec("slow_ack0", ack0, 1);
        check_vec("slow_rd_a", rd_a, 32'h22);
        check_vec("slow_rd_b", rd_b, 32'h11);
        req0 = 0; fin_delay = 0;
        tick();

        // Tie from reset: grants alternate starting with requester 0
        reset_n = 1'b0;
        req0 = 1; req1 = 1; addr_s0 = 3; addr_t0 = 3; addr_s1 = 4; addr_t1 = 4;
        tick(); tick();
        check_vec("tie_rst_ack0", ack0, 0);
        reset_n = 1'b1;
        n_ack = 0; starts = 0; dbl = 0; both = 0; prev = 0;
        for (int k = 0; k < 4; k++) ord[k] = 9;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            tick();
            if (rf_start) starts++;
            if (ack0 && ack1) both++;
            if ((ack0 || ack1) && prev) dbl++;
            prev = ack0 || ack1;
            if (ack0) begin ord[n_ack] = 0; n_ack++; end
            else if (ack1) begin ord[n_ack] = 1; n_ack++; end
        end
        check_vec("tie_acks", n_ack, 4);
        check_vec("tie_g0", ord[0], 0);
        check_vec("tie_g1", ord[1], 1);
        check_vec("tie_g2", ord[2], 0);
        check_vec("tie_g3", ord[3], 1);
        check_vec("tie_starts", starts, 4);
        check_vec("tie_dbl", dbl, 0);
        check_vec("tie_both", both, 0);
        check_vec("tie_rd_a", rd_a, 32'h22);
        req0 = 0; req1 = 0;
        tick();

        // Reset during WAIT abandons the transaction
        fin_hold = 1;
        req0 = 1; addr_s0 = 3; addr_t0 = 4;
        tick(); tick();
        check_vec("abort_in_wait", rf_read_enabled, 1);
        #2 reset_n = 1'b0;
        #1;
        check_vec("abort_ack0", ack0, 0);
        check_vec("abort_rden", rf_read_enabled, 0);
        check_vec("abort_raddr_s", rf_read_addr_s, 0);
        check_vec("abort_rd_a", rd_a, 0);
        check_vec("abort_rd_b", rd_b, 0);
        req0 = 0; fin_hold = 0;
        tick();
        reset_n = 1'b1;
        acks = 0;
        repeat (4) begin
            tick();
            if (ack0 || ack1) acks++;
        end
        check_vec("abort_no_ack", acks, 0);
        req0 = 1; addr_s0 = 3; addr_t0 = 4;
        tick(); tick(); tick();
        check_vec("post_abort_ack0", ack0, 1);
        check_vec("post_abort_rd_a", rd_a, 32'h11);
        check_vec("post_abort_rd_b", rd_b, 32'h22);
        req0 = 0;
        tick();

`ifdef RF_ARB_TIMEOUT_EN
        // Timeout after 16 WAIT cycles
        fin_hold = 1;
        req0 = 1; addr_s0 = 3; addr_t0 = 4;
        tick();
        early = 0;
        repeat (16) begin
            tick();
            if (ack0 || !rf_read_enabled) early++;
        end
        check_vec("to_wait16", early, 0);
        tick();
        check_vec("to_ack0", ack0, 1);
        check_vec("to_err", err, 1);
        check_vec("to_rd_a", rd_a, 0);
        check_vec("to_rd_b", rd_b, 0);
        req0 = 0; fin_hold = 0;
        tick();
        check_vec("to_err_clear", err, 0);

        // Finish in the timeout cycle resolves as finish
        fin_delay = 15;
        req0 = 1;
        tick();
        repeat (16) tick();
        tick();
        check_vec("tofin_ack0", ack0, 1);
        check_vec("tofin_err", err, 0);
        check_vec("tofin_rd_a", rd_a, 32'h11);
        req0 = 0; fin_delay = 0;
        tick();
`else
        // Without the timeout WAIT outlasts 16 cycles
        fin_delay = 20;
        req0 = 1; addr_s0 = 4; addr_t0 = 3;
        tick();
        early = 0;
        repeat (21) begin
            tick();
            if (ack0 || !rf_read_enabled) early++;
        end
        check_vec("long_wait", early, 0);
        tick();
        check_vec("long_ack0", ack0, 1);
        check_vec("long_err", err, 0);
        check_vec("long_rd_a", rd_a, 32'h22);
        req0 = 0; fin_delay = 0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
